// File: rtl/caixa_pkg.sv
// Shared definitions for the tank sensor front-end and the tank level FSM.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package caixa_pkg;

    // Fault supervisor states, shared with the level FSM.
    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_FAULT   = 2'd1,
        ST_RECOVER = 2'd2
    } caixa_state_e;

    // erro_code values: bit 0 = inconsistent set, bit 1 = level jump.
    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_INCONS = 2'b01;
    localparam logic [1:0] ERR_JUMP   = 2'b10;
    localparam logic [1:0] ERR_BOTH   = 2'b11;

    // Number of wet switches in a {high, mid, low} vector.
    function automatic logic [1:0] wet_count(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Water can only be present at a switch if every lower switch is wet.
    function automatic logic is_consistent(input logic [2:0] v);
        return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One float-switch input: 2-flop synchroniser followed by a debounce counter.
// Latency: 2 synchroniser edges + DEBOUNCE_CYCLES edges from a stable raw change to deb_o.
// Backpressure: none; free-running, one sample per clock.
// Ports: clock/reset (async active-low), raw_i (asynchronous switch), deb_o (clean bit).
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic deb_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter measures the current run of samples that disagree with
    // the debounced value; any agreeing sample throws the run away.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q + CNT_ONE == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/sensor_caixa.sv
// Tank sensor front-end: debounces low/mid/high float switches, checks consistency and level jumps, supervises faults.
// Latency: DEBOUNCE_CYCLES+3 edges from a stable raw change to upper/level; erro rises one edge after the offending debounced update.
// Backpressure: none; outputs are registered levels consumed directly by the level FSM.
// Ports: clock, reset (async active-low), s_low/s_mid/s_high (raw async switches), clr_erro (fault clear);
//        upper, erro -> level FSM; level (wet count 0..3), erro_code (fault cause) -> display.
module sensor_caixa
    import caixa_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       s_low,
    input  logic       s_mid,
    input  logic       s_high,
    input  logic       clr_erro,
    output logic       upper,
    output logic       erro,
    output logic [1:0] level,
    output logic [1:0] erro_code
);

    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic       deb_l;
    logic       deb_m;
    logic       deb_h;
    logic [2:0] deb_vec;

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_low (
        .clock(clock), .reset(reset), .raw_i(s_low),  .deb_o(deb_l)
    );
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_mid (
        .clock(clock), .reset(reset), .raw_i(s_mid),  .deb_o(deb_m)
    );
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_high (
        .clock(clock), .reset(reset), .raw_i(s_high), .deb_o(deb_h)
    );

    assign deb_vec = {deb_h, deb_m, deb_l};

    // ---------------- consistency and jump detection ----------------
    logic [2:0] vec_prev_q;
    logic       first_q;
    logic [1:0] lvl_cur;
    logic [1:0] lvl_prev;
    logic [1:0] lvl_diff;
    logic       incons;
    logic       jump;
    logic       fault;
    logic [1:0] fault_code;

    assign lvl_cur  = wet_count(deb_vec);
    assign lvl_prev = wet_count(vec_prev_q);
    assign lvl_diff = (lvl_cur >= lvl_prev) ? (lvl_cur - lvl_prev) : (lvl_prev - lvl_cur);
    assign incons   = ~is_consistent(deb_vec);

    // The reset value of the debounced vector is not a measurement, so the
    // first debounced update after reset has nothing to be compared against
    // and cannot count as a jump (a tank already at 011 must come up clean).
    assign jump  = ~first_q & (deb_vec != vec_prev_q) & (lvl_diff >= 2'd2);
    assign fault = incons | jump;

    always_comb begin
        fault_code = ERR_NONE;
        if (jump && incons) begin
            fault_code = ERR_BOTH;
        end else if (jump) begin
            fault_code = ERR_JUMP;
        end else if (incons) begin
            fault_code = ERR_INCONS;
        end
    end

    // ---------------- fault supervisor ----------------
    caixa_state_e     state_q;
    caixa_state_e     state_d;
    logic [CNT_W-1:0] rcnt_q;
    logic [CNT_W-1:0] rcnt_d;
    logic             upper_q;
    logic             upper_d;
    logic [1:0]       level_q;
    logic [1:0]       level_d;
    logic [1:0]       code_q;
    logic [1:0]       code_d;

    // upper/level only follow the sensors while healthy; the fault-entry
    // edge itself does not update them so they keep the last good value.
    // RECOVER leaves after DEBOUNCE_CYCLES+1 clean edges following the
    // accepted clear, which is when erro drops.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        upper_d = upper_q;
        level_d = level_q;
        code_d  = code_q;
        unique case (state_q)
            ST_OK: begin
                if (fault) begin
                    state_d = ST_FAULT;
                    code_d  = fault_code;
                end else begin
                    upper_d = deb_h;
                    level_d = lvl_cur;
                end
            end
            ST_FAULT: begin
                if (clr_erro && !incons) begin
                    state_d = ST_RECOVER;
                    rcnt_d  = '0;
                end
            end
            ST_RECOVER: begin
                if (fault) begin
                    state_d = ST_FAULT;
                    code_d  = fault_code;
                end else if (rcnt_q == REC_LAST) begin
                    state_d = ST_OK;
                    code_d  = ERR_NONE;
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_OK;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vec_prev_q <= 3'b000;
            first_q    <= 1'b1;
            state_q    <= ST_OK;
            rcnt_q     <= '0;
            upper_q    <= 1'b0;
            level_q    <= 2'd0;
            code_q     <= ERR_NONE;
        end else begin
            vec_prev_q <= deb_vec;
            first_q    <= first_q & (deb_vec == vec_prev_q);
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            upper_q    <= upper_d;
            level_q    <= level_d;
            code_q     <= code_d;
        end
    end

    assign upper     = upper_q;
    assign erro      = (state_q != ST_OK);
    assign level     = level_q;
    assign erro_code = code_q;

endmodule

// File: tb/tb_sensor_caixa.sv
// Bench for sensor_caixa: directed test-plan scenarios plus randomized switch patterns,
// each cycle's expected outputs come from a behavioural model and are compared by a monitor.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_sensor_caixa;

    localparam int D = 4;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       s_low    = 1'b0;
    logic       s_mid    = 1'b0;
    logic       s_high   = 1'b0;
    logic       clr_erro = 1'b0;
    logic       upper;
    logic       erro;
    logic [1:0] level;
    logic [1:0] erro_code;

    sensor_caixa #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .s_low(s_low), .s_mid(s_mid), .s_high(s_high), .clr_erro(clr_erro),
        .upper(upper), .erro(erro), .level(level), .erro_code(erro_code)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_OK = 0, M_FAULT = 1, M_REC = 2;

    logic [2:0] hist[$];     // raw {high,mid,low} seen at each edge since reset
    logic [2:0] samp[$];     // synchronised samples offered to the debouncers
    logic [2:0] m_deb;
    int         m_state;
    int         m_rec;
    logic       m_upper;
    logic [1:0] m_level;
    logic [1:0] m_code;
    logic       m_chg_last;  // debounced vector changed on the previous edge
    int         m_lvl_before;
    logic       m_any_update;
    logic       m_prior;     // that change had an earlier change to compare against
    logic [5:0] exp_q[$];

    function automatic int popc(input logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    task automatic m_reset();
        hist.delete();
        samp.delete();
        m_deb        = 3'b000;
        m_state      = M_OK;
        m_rec        = 0;
        m_upper      = 1'b0;
        m_level      = 2'd0;
        m_code       = 2'b00;
        m_chg_last   = 1'b0;
        m_lvl_before = 0;
        m_any_update = 1'b0;
        m_prior      = 1'b0;
    endtask

    always @(posedge clock or negedge reset) begin
        logic [2:0] s;
        logic [2:0] nd;
        logic       incons;
        logic       jump;
        logic       all_diff;
        int         dl;
        if (!reset) begin
            m_reset();
            exp_q.delete();
            exp_q.push_back(6'b0);
        end else begin
            // Supervisor acts on the debounced vector as it stood before this edge.
            incons = !(m_deb inside {3'b000, 3'b001, 3'b011, 3'b111});
            dl = popc(m_deb) - m_lvl_before;
            if (dl < 0) dl = -dl;
            jump = m_chg_last && m_prior && (dl >= 2);
            if (m_state == M_OK) begin
                if (incons || jump) begin
                    m_state = M_FAULT;
                    m_code  = {jump, incons};
                end else begin
                    m_upper = m_deb[2];
                    m_level = 2'(popc(m_deb));
                end
            end else if (m_state == M_FAULT) begin
                if (clr_erro && !incons) begin
                    m_state = M_REC;
                    m_rec   = 0;
                end
            end else begin
                if (incons || jump) begin
                    m_state = M_FAULT;
                    m_code  = {jump, incons};
                end else begin
                    m_rec++;
                    if (m_rec == D + 1) begin
                        m_state = M_OK;
                        m_code  = 2'b00;
                    end
                end
            end
            // A debounced bit flips once the last D samples all disagree with it.
            s = (hist.size() >= 2) ? hist[hist.size()-2] : 3'b000;
            samp.push_back(s);
            if (samp.size() > 16) void'(samp.pop_front());
            nd = m_deb;
            if (samp.size() >= D) begin
                for (int b = 0; b < 3; b++) begin
                    all_diff = 1'b1;
                    for (int k = 1; k <= D; k++)
                        if (samp[samp.size()-k][b] == m_deb[b]) all_diff = 1'b0;
                    if (all_diff) nd[b] = ~m_deb[b];
                end
            end
            m_chg_last = (nd != m_deb);
            if (m_chg_last) begin
                m_prior      = m_any_update;
                m_any_update = 1'b1;
                m_lvl_before = popc(m_deb);
            end
            m_deb = nd;
            hist.push_back({s_high, s_mid, s_low});
            if (hist.size() > 4) void'(hist.pop_front());
            exp_q.push_back({m_upper, (m_state != M_OK), m_level, m_code});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        logic [5:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_underflow at %0t: no expected entry", $time);
        end else begin
            e = exp_q.pop_front();
            if ({upper, erro, level, erro_code} !== e) begin
                n_errors++;
                $display("FAIL scoreboard at %0t: got upper=%0b erro=%0b level=%0d code=%b, expected upper=%0b erro=%0b level=%0d code=%b",
                         $time, upper, erro, level, erro_code, e[5], e[4], e[3:2], e[1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_raw(input logic [2:0] v);
        {s_high, s_mid, s_low} = v;
    endtask

    task automatic pulse_clr();
        clr_erro = 1'b1;
        step(1);
        clr_erro = 1'b0;
    endtask

    // Called 1 unit after an edge: reset drops between edges, outputs must clear at once.
    task automatic async_reset(input string tag);
        #1;
        reset = 1'b0;
        #1;
        check({tag, "_outputs_in_reset"}, {2'b00, upper, erro, level, erro_code}, 8'h00);
        step(1);
        reset = 1'b1;
    endtask

    initial begin
        step(3);
        check("reset_state", {2'b00, upper, erro, level, erro_code}, 8'h00);
        reset = 1'b1;
        step(3);

        // Clean fill: each level step appears exactly D+3 edges after its raw edge.
        set_raw(3'b001);
        step(D + 2); check("fill1_before", 8'(level), 8'd0);
        step(1);     check("fill1_level", 8'(level), 8'd1);
        step(13);
        set_raw(3'b011);
        step(D + 2); check("fill2_before", 8'(level), 8'd1);
        step(1);     check("fill2_level", 8'(level), 8'd2);
        step(13);
        set_raw(3'b111);
        step(D + 2); check("fill3_upper_before", 8'(upper), 8'd0);
        step(1);     check("fill3_level", 8'(level), 8'd3);
                     check("fill3_upper", 8'(upper), 8'd1);
                     check("fill_erro", 8'(erro), 8'd0);
        step(13);
        set_raw(3'b011);
        step(20);    check("drain_to_2", 8'(level), 8'd2);

        // Glitch rejection: a pulse shorter than D leaves everything alone.
        set_raw(3'b111);
        step(D - 1);
        set_raw(3'b011);
        step(20);
        check("glitch_level", 8'(level), 8'd2);
        check("glitch_upper", 8'(upper), 8'd0);
        check("glitch_erro", 8'(erro), 8'd0);
        set_raw(3'b001); step(20);
        set_raw(3'b000); step(20);
        check("drain_to_0", 8'(level), 8'd0);

        // Inconsistent set, then clear.
        set_raw(3'b100);
        step(D + 2); check("incons_erro_before", 8'(erro), 8'd0);
        step(1);     check("incons_erro", 8'(erro), 8'd1);
                     check("incons_code", 8'(erro_code), 8'd1);
                     check("incons_upper_frozen", 8'(upper), 8'd0);
        set_raw(3'b000);
        step(10);
        pulse_clr();
        step(D);     check("clear_erro_still_set", 8'(erro), 8'd1);
        step(1);     check("clear_erro_drop", 8'(erro), 8'd0);
                     check("clear_code_none", 8'(erro_code), 8'd0);

        // Jump: two bits rise together from 000.
        set_raw(3'b011);
        step(D + 3);
        check("jump_erro", 8'(erro), 8'd1);
        check("jump_code", 8'(erro_code), 8'd2);
        check("jump_level_held", 8'(level), 8'd0);

        // Bad clear on 101, then inconsistency during RECOVER.
        set_raw(3'b101);
        step(8);
        clr_erro = 1'b1; step(2); clr_erro = 1'b0;
        check("badclear_erro", 8'(erro), 8'd1);
        set_raw(3'b001);
        step(8);
        set_raw(3'b010);
        step(2);
        pulse_clr();
        step(3);     check("recover_code_held", 8'(erro_code), 8'd2);
        step(1);     check("recover_refault_code", 8'(erro_code), 8'd1);
                     check("recover_refault_erro", 8'(erro), 8'd1);

        // Asynchronous reset while in FAULT, then a stable 011 comes up clean.
        step(1);
        set_raw(3'b011);
        async_reset("fault");
        step(D + 2); check("post_reset_before", 8'(level), 8'd0);
        step(1);     check("post_reset_level", 8'(level), 8'd2);
                     check("post_reset_erro", 8'(erro), 8'd0);

        // Randomized segments; the scoreboard carries the checking.
        for (int seg = 0; seg < 250; seg++) begin
            logic [2:0] v;
            int         hold;
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0:       v = 3'b000;
                    1:       v = 3'b001;
                    2:       v = 3'b011;
                    default: v = 3'b111;
                endcase
            end else begin
                v = 3'($urandom_range(0, 7));
            end
            set_raw(v);
            hold = int'($urandom_range(1, 12));
            for (int k = 0; k < hold; k++) begin
                clr_erro = ($urandom_range(0, 3) == 0);
                step(1);
            end
            clr_erro = 1'b0;
            if ($urandom_range(0, 49) == 0) async_reset("random");
        end

        step(2);
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sensor_caixa.md
# sensor_caixa

Front-end conditioning stage for the tank level controller. It takes the three raw float-switch inputs (low, mid, high), synchronises and debounces each one, and checks the set for physical consistency. It then drives the `upper` and `erro` inputs of the tank level FSM directly, plus a 2-bit level and an error code for display. Everything is registered: the downstream FSM sees only clean, glitch-free, cycle-aligned signals.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronised samples required before a debounced sensor bit changes; legal range 1..15.
- `CNT_W`, default 4: width of each debounce counter; must hold `DEBOUNCE_CYCLES`.

- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `s_low` in 1: raw low switch; 1 = water present. Asynchronous to `clock`.
- `s_mid` in 1: raw mid switch; 1 = water present. Asynchronous.
- `s_high` in 1: raw high switch; 1 = water present. Asynchronous.
- `clr_erro` in 1: operator fault-clear request, synchronous, level-sampled.
- `upper` out 1: debounced high switch, fed to the level FSM.
- `erro` out 1: sensor fault flag, fed to the level FSM.
- `level` out 2: number of debounced switches wet, 0..3.
- `erro_code` out 2: 00 none, 01 inconsistent set, 10 level jump, 11 both; captured on fault entry.

## Operation
- **Synchroniser:** each raw input passes through a 2-flop synchroniser; both flops reset to 0.
- **Debounce (per bit):**
  - The counter clears whenever the synchronised sample equals the debounced value.
  - Otherwise it increments.
  - When it reaches `DEBOUNCE_CYCLES`, the debounced value takes the sample and the counter clears.
  - A single differing sample followed by a return to the old value clears the counter; no change results.
- **Consistency:** the debounced vector {high, mid, low} is consistent only for 000, 001, 011 or 111. Any other pattern is an inconsistency.
- **Jump detection:** a level jump is a change of `level` by 2 or more between consecutive debounced updates, e.g. 0→2 or 3→1.
- **FSM states:** OK, FAULT, RECOVER.
  - OK → FAULT on an inconsistency or a jump. `erro_code` is captured from the conditions present on that cycle. If both occur together, code 11.
  - FAULT → RECOVER when `clr_erro`=1 and the vector is consistent. With `clr_erro`=1 on an inconsistent vector, stay in FAULT.
  - RECOVER → OK after `DEBOUNCE_CYCLES` consecutive consistent cycles with no jump. Any inconsistency or jump returns to FAULT with a fresh `erro_code`.
- **Outputs:**
  - `erro` = 1 in FAULT and RECOVER.
  - `upper` and `level` track debounced data in OK only. They are frozen at the last OK value in FAULT and RECOVER.
  - `erro_code` holds its value until the RECOVER→OK transition, then returns to 00.

## Timing
- **Reset:** all outputs 0 (`upper`=0, `erro`=0, `level`=0, `erro_code`=00); FSM in OK; synchronisers, debounced bits and counters all 0.
- **Normal latency:** a raw input change held stable with no fault appears at the outputs `DEBOUNCE_CYCLES`+3 rising edges later. That is 2 synchroniser edges + `DEBOUNCE_CYCLES` debounce edges + 1 output register edge.
- **Fault latency:**
  - `erro` rises on the output-register edge following the debounced update that creates the fault.
  - `erro` falls `DEBOUNCE_CYCLES`+1 edges after the first `clr_erro` sample that is accepted in FAULT.
- **`clr_erro`:**
  - In OK it has no effect.
  - Held high continuously, it is accepted once; RECOVER ignores it.
- **Reset mid-operation:** asserting `reset` at any point forces the reset values immediately, independent of `clock`. Counters restart on deassertion.
- **Simultaneous events:** several bits may update on the same edge. Consistency and jump are evaluated on the resulting vector only.

## Structure
- **Shared package `caixa_pkg`:** FSM state enum (OK/FAULT/RECOVER) and the `erro_code` constants (`ERR_NONE`, `ERR_INCONS`, `ERR_JUMP`, `ERR_BOTH`). The level FSM reuses the package.
- **Sub-module `debounce_bit`:** synchroniser + counter + debounced flop. Parameterised by `DEBOUNCE_CYCLES`/`CNT_W` and instantiated three times.
- **Top level:** consistency and jump logic, FSM and output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Clean fill:** raise `s_low`, `s_mid` and `s_high` in turn, 20 cycles apart → each `level` step (1, 2, 3) appears exactly 7 edges after its raw edge; `upper`=1 7 edges after `s_high`; `erro` stays 0.
- **Glitch rejection:** `s_high` pulses 1 for 3 cycles from level 2 → `upper`, `level` and `erro` unchanged.
- **Inconsistent set:** from 000, raise only `s_high` → `erro`=1, `erro_code`=01, `upper` frozen at 0. Drop `s_high` and pulse `clr_erro` → `erro`=0 5 edges after the `clr_erro` sample.
- **Jump:** from 000, raise `s_low` and `s_mid` on the same cycle → `erro_code`=10 and `level` held at 0.
- **Bad clear:** `clr_erro`=1 while {high,mid,low}=101 → stays FAULT, `erro`=1. Inconsistency during RECOVER → back to FAULT with the new code.
- **Async reset:** assert `reset`=0 between clock edges while in FAULT → all outputs 0 immediately; after release, a stable 011 input gives `level`=2 after 7 edges.
